// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: timed HD44780 read cycles (BF/AC or data RAM) via valid/ready; busy poll under LCD_READER_BUSY_POLL_EN
module lcd_bus_reader #(
  parameter int T_AS = 3,
  parameter int T_EN = 25,
  parameter int T_H = 2,
  parameter int T_GAP = 50,
  parameter int POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  output logic       ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       bus_active,
  input  logic       poll_req,
  output logic       poll_done,
  output logic       poll_timeout,
  output logic [6:0] ac_out
);
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, load, rsp_data_d;
  logic [6:0] ac_d;
  logic rs_l, rs_n, last, sample, on;
  logic ready_d, rsp_valid_d, rs_d, rw_d, en_d, bus_d;
  logic polling, poll_more, start_poll;
  assign last = cnt == 8'd0;
  assign sample = state == EN_HI && last;
`ifdef LCD_READER_BUSY_POLL_EN
  logic [15:0] poll_cnt;
  assign start_poll = state == IDLE && !req_valid && poll_req;
  assign poll_more = polling && rsp_data[7] && poll_cnt != 16'(POLL_MAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      polling <= 1'b0;
      poll_cnt <= 16'd0;
      poll_done <= 1'b0;
      poll_timeout <= 1'b0;
    end else begin
      polling <= start_poll ? 1'b1 : (state == GAP && last && !poll_more) ? 1'b0 : polling;
      poll_cnt <= start_poll ? 16'd0 : (polling && sample) ? poll_cnt + 16'd1 : poll_cnt;
      poll_done <= polling && state == HOLD && last && !poll_more;
      poll_timeout <= polling && state == HOLD && last && rsp_data[7] && poll_cnt == 16'(POLL_MAX);
    end
  end
`else
  logic unused_poll;
  assign unused_poll = poll_req;
  assign start_poll = 1'b0;
  assign polling = 1'b0;
  assign poll_more = 1'b0;
  assign poll_done = 1'b0;
  assign poll_timeout = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE ? ((req_valid || start_poll) ? SETUP : IDLE)
            : !last ? state
            : state == SETUP ? EN_HI
            : state == EN_HI ? HOLD
            : state == HOLD ? GAP
            : poll_more ? SETUP : IDLE;
    load = state_n == SETUP ? 8'(T_AS - 1)
         : state_n == EN_HI ? 8'(T_EN - 1)
         : state_n == HOLD ? 8'(T_H - 1)
         : state_n == GAP ? 8'(T_GAP - 1) : 8'd0;
    cnt_n = state_n != state ? load : last ? 8'd0 : cnt - 8'd1;
    rs_n = state == IDLE ? (req_valid & req_rs) : rs_l;
  end
  always_comb begin
    on = state_n inside {SETUP, EN_HI, HOLD};
    ready_d = state_n == IDLE;
    en_d = state_n == EN_HI;
    rw_d = on;
    bus_d = on;
    rs_d = on & rs_n;
    rsp_valid_d = state == HOLD && last && !polling;
    rsp_data_d = sample ? lcd_data_in : rsp_data;
    ac_d = (sample && !rs_l) ? lcd_data_in[6:0] : ac_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      rs_l <= 1'b0;
      ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data <= 8'd0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      lcd_en <= 1'b0;
      bus_active <= 1'b0;
      ac_out <= 7'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rs_l <= rs_n;
      ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data <= rsp_data_d;
      lcd_rs <= rs_d;
      lcd_rw <= rw_d;
      lcd_en <= en_d;
      bus_active <= bus_d;
      ac_out <= ac_d;
    end
  end
endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: randomized scoreboard bench for lcd_bus_reader
module tb_lcd_bus_reader;
  localparam int T_AS = 3, T_EN = 25, T_H = 2, T_GAP = 50, POLL_MAX = 4;
  localparam int LAT = T_AS + T_EN + T_H;
  localparam int PER = LAT + T_GAP;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_rs = 1'b0, poll_req = 1'b0;
  logic [7:0] lcd_data_in = 8'd0;
  logic ready, rsp_valid, lcd_rs, lcd_rw, lcd_en, bus_active, poll_done, poll_timeout;
  logic [7:0] rsp_data;
  logic [6:0] ac_out;
  lcd_bus_reader #(.T_AS(T_AS), .T_EN(T_EN), .T_H(T_H), .T_GAP(T_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs), .ready(ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .lcd_data_in(lcd_data_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .bus_active(bus_active),
    .poll_req(poll_req), .poll_done(poll_done), .poll_timeout(poll_timeout), .ac_out(ac_out)
  );
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [7:0] d; logic [6:0] ac; int t;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  logic [6:0] ac_model = 7'd0;
  logic mon_en = 1'b0, exp_rs = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (q.size() == 0) chk("unexpected rsp_valid", 1, 0);
      else begin
        e_mon = q.pop_front();
        chk("rsp_data", rsp_data, e_mon.d);
        chk("ac_out", ac_out, e_mon.ac);
        chk("rsp latency", cyc, e_mon.t);
      end
    end
  end
  logic rw_q = 1'b0, en_q = 1'b0, rdy_q = 1'b1;
  int rw_t = 0, en_t = 0, enf_t = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (lcd_rw && !rw_q) begin
        rw_t = cyc;
        chk("lcd_rs", lcd_rs, exp_rs);
      end
      if (lcd_en && !en_q) begin
        en_t = cyc;
        chk("setup cycles", cyc - rw_t, T_AS);
      end
      if (!lcd_en && en_q) begin
        enf_t = cyc;
        chk("en high cycles", cyc - en_t, T_EN);
      end
      if (!lcd_rw && rw_q) chk("hold cycles", cyc - enf_t, T_H);
      if (ready && !rdy_q) chk("ready return", cyc - rw_t, PER);
    end
    rw_q = lcd_rw;
    en_q = lcd_en;
    rdy_q = ready;
  end
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("wait ready timeout", ready, 1);
  endtask
  task automatic issue(input logic rs, input logic [7:0] d, input logic push, output int acc);
    exp_t e;
    wait_ready();
    req_rs = rs;
    lcd_data_in = d;
    exp_rs = rs;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    if (push) begin
      e.d = d;
      e.ac = rs ? ac_model : d[6:0];
      ac_model = e.ac;
      e.t = acc + LAT;
      q.push_back(e);
    end
  endtask
`ifdef LCD_READER_BUSY_POLL_EN
  task automatic poll_run(input logic [7:0] busy, input logic [7:0] free, input int n_busy);
    int reads, n, exp_reads;
    logic prev, done;
    logic [7:0] last_v;
    wait_ready();
    exp_rs = 1'b0;
    lcd_data_in = n_busy > 0 ? busy : free;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    prev = lcd_rw;
    reads = 1;
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (lcd_rw && !prev) begin
        reads++;
        lcd_data_in = reads <= n_busy ? busy : free;
      end
      prev = lcd_rw;
      if (rsp_valid) chk("rsp_valid during poll", rsp_valid, 0);
      if (poll_done) done = 1'b1;
    end
    exp_reads = n_busy < POLL_MAX ? n_busy + 1 : POLL_MAX;
    last_v = exp_reads <= n_busy ? busy : free;
    chk("poll finished", done, 1);
    chk("poll reads", reads, exp_reads);
    chk("poll_timeout", poll_timeout, n_busy >= POLL_MAX);
    chk("poll ac_out", ac_out, last_v[6:0]);
    chk("ready during poll", ready, 0);
    ac_model = last_v[6:0];
    @(negedge clk);
    chk("poll_done pulse", poll_done, 0);
  endtask
`endif
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, rises, rise_t, cnt_v;
    logic prev;
    logic [7:0] d;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset ready", ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset lcd_en", lcd_en, 0);
    chk("reset lcd_rw", lcd_rw, 0);
    chk("reset lcd_rs", lcd_rs, 0);
    chk("reset bus_active", bus_active, 0);
    chk("reset poll_done", poll_done, 0);
    chk("reset poll_timeout", poll_timeout, 0);
    chk("reset ac_out", ac_out, 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    issue(1'b1, 8'h41, 1'b1, acc);
    issue(1'b0, 8'h8F, 1'b1, acc);
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      issue(1'($urandom_range(0, 1)), d, 1'b1, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_ready();
    req_rs = 1'b1;
    exp_rs = 1'b1;
    lcd_data_in = 8'h5A;
    req_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    for (int k = 0; k < 2; k++) begin
      e.d = 8'h5A;
      e.ac = ac_model;
      e.t = acc + k * (PER + 1) + LAT;
      q.push_back(e);
    end
    prev = lcd_rw;
    rises = 0;
    rise_t = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (lcd_rw && !prev) begin
        rises++;
        rise_t = cyc;
      end
      prev = lcd_rw;
    end
    req_valid = 1'b0;
    chk("held req extra accepts", rises, 1);
    chk("held req second accept", rise_t, acc + PER + 1);
    issue(1'b1, 8'h33, 1'b0, acc);
    while (cyc < acc + 9) @(negedge clk);
    chk("en high before reset", lcd_en, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort lcd_en", lcd_en, 0);
    chk("abort bus_active", bus_active, 0);
    chk("abort ready", ready, 1);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort ac_out", ac_out, 0);
    rst = 1'b0;
    ac_model = 7'd0;
    cnt_v = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid || poll_done || bus_active) cnt_v++;
    end
    chk("no activity after abort", cnt_v, 0);
    mon_en = 1'b1;
`ifdef LCD_READER_BUSY_POLL_EN
    poll_run(8'h85, 8'h05, 2);
    poll_run(8'h80, 8'h80, 10);
    issue(1'b0, 8'h17, 1'b1, acc);
`else
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    cnt_v = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_active || poll_done || poll_timeout || !ready) cnt_v++;
    end
    chk("poll_req ignored", cnt_v, 0);
`endif
    for (int i = 0; i < 4; i++) issue(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, acc);
    cnt_v = 0;
    while (q.size() != 0 && cnt_v < 500) begin
      @(negedge clk);
      cnt_v++;
    end
    chk("scoreboard drained", q.size(), 0);
    wait_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
